// File: rtl/tensor_fifo_skew_reader.sv
// Drains a tile from the per-row FIFO bank into the systolic array with a diagonal skew,
// then flushes the array, pulses load_en and reports done.
//
// state  | meaning
// IDLE   | waiting for start
// STREAM | wavefront step t: lanes with i <= t < i+depth read, whole step stalls on any empty due lane
// FLUSH  | last data beat on a_out, then 2*SIZE-1 zero-operand cycles with mult_en/acc_en high
// LOAD   | load_en pulse, array latches results to d_out
// DONE   | done pulse, start ignored
module tensor_fifo_skew_reader #(
  parameter int DATAWIDTH = 14,
  parameter int SIZE      = 4,
  parameter int MAXDEPTH  = 1024,
  localparam int CW       = $clog2(MAXDEPTH + SIZE + 1)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic [CW-1:0]             depth,
  input  logic [SIZE-1:0]           fifo_empty,
  input  logic [SIZE*DATAWIDTH-1:0] fifo_q,
  output logic [SIZE-1:0]           fifo_rdreq,
  output logic [SIZE*DATAWIDTH-1:0] a_out,
  output logic                      mult_en,
  output logic                      acc_en,
  output logic                      load_en,
  output logic                      busy,
  output logic                      done
);

  localparam int FW = $clog2(2*SIZE + 1);

  typedef enum logic [2:0] {IDLE, STREAM, FLUSH, LOAD, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   t;
  logic [CW-1:0]   depth_q;
  logic [CW-1:0]   last_t;
  logic [FW-1:0]   fcnt;
  logic [SIZE-1:0] due;
  logic [SIZE-1:0] rd_q;
  logic            stall;

  assign last_t = depth_q + CW'(SIZE) - CW'(2);

  always_comb begin
    due = '0;
    for (int i = 0; i < SIZE; i++) begin
      due[i] = (state == STREAM) && (t >= CW'(i)) &&
               ({1'b0, t} < ({1'b0, depth_q} + (CW+1)'(i)));
    end
  end

  // A stall blocks the whole wavefront so lanes never drift apart.
  assign stall      = |(due & fifo_empty);
  assign fifo_rdreq = stall ? '0 : due;
  assign acc_en     = mult_en;

  // fifo_q already is the FIFO's output register; rd_q marks lanes whose word arrived this cycle.
  always_comb begin
    a_out = '0;
    for (int i = 0; i < SIZE; i++) begin
      a_out[i*DATAWIDTH +: DATAWIDTH] = rd_q[i] ? fifo_q[i*DATAWIDTH +: DATAWIDTH] : '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      t       <= '0;
      depth_q <= '0;
      fcnt    <= '0;
      rd_q    <= '0;
      mult_en <= 1'b0;
      load_en <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      rd_q    <= '0;
      mult_en <= 1'b0;
      load_en <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            depth_q <= depth;
            t       <= '0;
            busy    <= 1'b1;
            if (depth != '0) begin
              state <= STREAM;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        STREAM: begin
          rd_q <= fifo_rdreq;
          if (!stall) begin
            mult_en <= 1'b1;
            if (t == last_t) begin
              state <= FLUSH;
              fcnt  <= '0;
            end else begin
              t <= t + 1'b1;
            end
          end
        end
        FLUSH: begin
          fcnt <= fcnt + 1'b1;
          if (fcnt == FW'(2*SIZE - 1)) begin
            state   <= LOAD;
            load_en <= 1'b1;
          end else begin
            mult_en <= 1'b1;
          end
        end
        LOAD: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tensor_fifo_skew_reader.sv
// Scoreboard bench for tensor_fifo_skew_reader: FIFO bank model, directed tiles, then random
// tiles with random starvation and spurious start pulses.
module tb_tensor_fifo_skew_reader;

  localparam int DW   = 14;
  localparam int SIZE = 4;
  localparam int MAXD = 1024;
  localparam int CW   = $clog2(MAXD + SIZE + 1);

  logic                 clk;
  logic                 reset;
  logic                 start;
  logic [CW-1:0]        depth;
  logic [SIZE-1:0]      fifo_empty;
  logic [SIZE*DW-1:0]   fifo_q;
  logic [SIZE-1:0]      fifo_rdreq;
  logic [SIZE*DW-1:0]   a_out;
  logic                 mult_en;
  logic                 acc_en;
  logic                 load_en;
  logic                 busy;
  logic                 done;

  tensor_fifo_skew_reader #(.DATAWIDTH(DW), .SIZE(SIZE), .MAXDEPTH(MAXD)) dut (
    .clk(clk), .reset(reset), .start(start), .depth(depth),
    .fifo_empty(fifo_empty), .fifo_q(fifo_q), .fifo_rdreq(fifo_rdreq),
    .a_out(a_out), .mult_en(mult_en), .acc_en(acc_en), .load_en(load_en),
    .busy(busy), .done(done)
  );

  typedef struct {
    int               kind;  // 0 beat, 1 load, 2 done
    logic [SIZE*DW-1:0] a;
  } exp_t;

  exp_t exp_q[$];
  int   lat_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int done_cnt = 0;
  bit chk_idle = 0;
  bit end_req = 0;

  logic [DW-1:0]   mem [SIZE][64];
  int              wr_cnt [SIZE];
  int              rd_cnt [SIZE];
  logic [SIZE-1:0] force_e;
  logic [SIZE-1:0] rd_s;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Non-show-ahead FIFO bank: a word read in cycle c appears on fifo_q in cycle c+1.
  initial begin
    fifo_q = '0;
    fifo_empty = '1;
    rd_s = '0;
    for (int i = 0; i < SIZE; i++) rd_cnt[i] = 0;
    forever begin
      @(negedge clk);
      rd_s = fifo_rdreq;
      @(posedge clk);
      #2;
      if (!reset) rd_s = '0;
      for (int i = 0; i < SIZE; i++) begin
        if (rd_s[i]) begin
          fifo_q[i*DW +: DW] = mem[i][rd_cnt[i] % 64];
          rd_cnt[i] = rd_cnt[i] + 1;
        end
        fifo_empty[i] = (rd_cnt[i] >= wr_cnt[i]) || force_e[i];
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   n;
    int   kind;
    int   l;
    if (!reset) begin
      exp_q.delete();
      lat_q.delete();
      chk_idle = 0;
      checks++;
      if (fifo_rdreq != '0 || a_out != '0 || mult_en || acc_en || load_en || busy || done) begin
        errors++;
        $display("FAIL reset_outputs: rdreq=%b a_out=%h mult=%b acc=%b load=%b busy=%b done=%b, required all 0",
                 fifo_rdreq, a_out, mult_en, acc_en, load_en, busy, done);
      end
    end else begin
      if (chk_idle) begin
        checks++;
        chk_idle = 0;
        if (busy || mult_en || load_en || done || fifo_rdreq != '0) begin
          errors++;
          $display("FAIL idle_after_done: busy=%b mult=%b load=%b done=%b rdreq=%b, required all 0",
                   busy, mult_en, load_en, done, fifo_rdreq);
        end
      end
      if (fifo_rdreq != '0) begin
        checks++;
        if ((fifo_rdreq & fifo_empty) != '0) begin
          errors++;
          $display("FAIL rdreq_empty: rdreq=%b empty=%b, required no overlap", fifo_rdreq, fifo_empty);
        end
      end
      if (mult_en || acc_en) begin
        checks++;
        if (acc_en !== mult_en) begin
          errors++;
          $display("FAIL acc_en: acc_en=%b required %b", acc_en, mult_en);
        end
      end
      n = int'(mult_en) + int'(load_en) + int'(done);
      if (n > 1) begin
        checks++;
        errors++;
        $display("FAIL overlap: mult=%b load=%b done=%b, required at most one", mult_en, load_en, done);
      end else if (n == 1) begin
        checks++;
        kind = mult_en ? 0 : (load_en ? 1 : 2);
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_output: kind=%0d a_out=%h, required nothing", kind, a_out);
        end else begin
          e = exp_q.pop_front();
          if (kind != e.kind || a_out !== e.a || busy !== 1'b1) begin
            errors++;
            $display("FAIL stream: kind=%0d a_out=%h busy=%b, required kind=%0d a_out=%h busy=1",
                     kind, a_out, busy, e.kind, e.a);
          end
        end
      end else begin
        checks++;
        if (a_out != '0) begin
          errors++;
          $display("FAIL idle_a_out: a_out=%h required 0", a_out);
        end
      end
      if (done) begin
        chk_idle = 1;
        done_cnt++;
        if (lat_q.size() > 0) begin
          l = lat_q.pop_front();
          if (l >= 0) begin
            checks++;
            if (cyc != l) begin
              errors++;
              $display("FAIL done_cycle: done at cycle %0d required %0d", cyc, l);
            end
          end
        end
      end
    end
    if (end_req) begin
      checks++;
      if (exp_q.size() != 0) begin
        errors++;
        $display("FAIL leftover: %0d expected outputs never seen, required 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: at wavefront step t lane i carries its word t-i when 0 <= t-i < d.
  task automatic start_tile(input int d, input bit pat, input int lat);
    logic [DW-1:0]      dat [SIZE][16];
    logic [SIZE*DW-1:0] v;
    exp_t               e;
    for (int i = 0; i < SIZE; i++) begin
      for (int k = 0; k < d; k++) begin
        dat[i][k] = pat ? DW'(i*16 + k) : DW'($urandom_range(1, 16383));
        mem[i][(wr_cnt[i] + k) % 64] = dat[i][k];
      end
      wr_cnt[i] = wr_cnt[i] + d;
    end
    if (d > 0) begin
      for (int t = 0; t <= d + SIZE - 2; t++) begin
        v = '0;
        for (int i = 0; i < SIZE; i++)
          if (t >= i && t - i < d) v[i*DW +: DW] = dat[i][t-i];
        e.kind = 0; e.a = v; exp_q.push_back(e);
      end
      for (int f = 0; f < 2*SIZE - 1; f++) begin
        e.kind = 0; e.a = '0; exp_q.push_back(e);
      end
      e.kind = 1; e.a = '0; exp_q.push_back(e);
    end
    e.kind = 2; e.a = '0; exp_q.push_back(e);
    lat_q.push_back(lat < 0 ? -1 : cyc + lat);
    start = 1'b1;
    depth = CW'(d);
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input bit rnd);
    int  dc0;
    bit  seen;
    dc0 = done_cnt;
    seen = 0;
    for (int n = 0; n < budget; n++) begin
      tick();
      start = 1'b0;
      if (done_cnt > dc0) begin
        seen = 1;
        break;
      end
      if (rnd) begin
        force_e = ($urandom_range(0, 3) == 0) ? SIZE'(1 << $urandom_range(0, SIZE-1)) : '0;
        if ($urandom_range(0, 9) == 0) begin
          start = 1'b1;
          depth = CW'($urandom_range(0, 20));
        end
      end
    end
    force_e = '0;
    if (!seen) begin
      $display("FAIL done_timeout: no done within %0d cycles", budget);
      $fatal(1, "done timeout");
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    depth = '0;
    force_e = '0;
    for (int i = 0; i < SIZE; i++) wr_cnt[i] = 0;
    #1 reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    tick();

    // full FIFOs, no stalls, recognisable lane data
    start_tile(3, 1, 16);
    wait_done(100, 0);
    tick();

    // depth 0: done the cycle after start, nothing else
    start_tile(0, 0, 1);
    wait_done(20, 0);
    tick();

    // lane 1 starved for 3 cycles at step 2
    start_tile(3, 0, 19);
    tick();
    tick();
    force_e = 4'b0010;
    repeat (3) tick();
    force_e = '0;
    wait_done(100, 0);
    tick();

    // start with depth 9 while streaming is ignored
    start_tile(3, 1, 16);
    tick();
    start = 1'b1;
    depth = CW'(9);
    tick();
    start = 1'b0;
    wait_done(100, 0);
    tick();

    // reset mid-tile at step 2, then a clean tile
    start_tile(3, 0, -1);
    tick();
    tick();
    #2 reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < SIZE; i++) wr_cnt[i] = rd_cnt[i];
    tick();
    start_tile(2, 0, 15);
    wait_done(100, 0);
    tick();

    for (int k = 0; k < 24; k++) begin
      start_tile($urandom_range(0, 12), 0, -1);
      wait_done(400, 1);
    end

    tick();
    end_req = 1;
    repeat (3) @(posedge clk);
    $display("FAIL end_not_reached: summary never printed");
    $fatal(1, "end not reached");
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

endmodule
